// File: rtl/lock_entry_controller.sv
// Code-entry sequencer for the automatic lock: converts button levels to single-cycle symbols,
// checks a CODE_LEN-symbol entry, and manages unlock hold, inter-symbol timeout and lockout.
module lock_entry_controller #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1010,
    parameter int                  TIMEOUT        = 1000,
    parameter int                  UNLOCK_CYCLES  = 500,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 5000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Btn_A,
    input  logic       Btn_B,
    input  logic       Lock_Cmd,
    output logic [1:0] Symbol,
    output logic       Symbol_Valid,
    output logic       Seq_Restart,
    output logic       Unlocked,
    output logic       Locked_Out,
    output logic [1:0] Fail_Count,
    output logic [2:0] State_Code
);

    localparam int TMR_MAX_A = (TIMEOUT > UNLOCK_CYCLES) ? TIMEOUT : UNLOCK_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > LOCKOUT_CYCLES) ? TMR_MAX_A : LOCKOUT_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int CNT_W     = $clog2(CODE_LEN + 1);

    localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] UNLOCK_V  = TMR_W'(UNLOCK_CYCLES);
    localparam logic [TMR_W-1:0] LOCKOUT_V = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] LEN_V     = CNT_W'(CODE_LEN);
    localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [1:0]          fail_q, fail_d;
    logic                prev_a_q, prev_b_q;
    logic [1:0]          symbol_q, symbol_d;
    logic                valid_q, valid_d;
    logic                restart_q, restart_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;

    logic press_a, press_b, press, sym_accept;

    // A press needs a clean rising edge on one button while the other is released.
    assign press_a = Btn_A & ~prev_a_q & ~Btn_B;
    assign press_b = Btn_B & ~prev_b_q & ~Btn_A;
    assign press   = press_a | press_b;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        sym_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    sym_accept = 1'b1;
                    shift_d    = CODE_LEN'(press_a);
                    count_d    = CNT_W'(1);
                    timer_d    = '0;
                    state_d    = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (Lock_Cmd) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    timer_d = '0;
                end else if (press) begin
                    sym_accept = 1'b1;
                    shift_d    = (shift_q << 1) | CODE_LEN'(press_a);
                    count_d    = count_q + CNT_W'(1);
                    timer_d    = '0;
                    if (count_d == LEN_V) begin
                        state_d = S_CHECK;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_d == TIMEOUT_V) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        timer_d = '0;
                    end
                end
            end
            S_CHECK: begin
                count_d = '0;
                timer_d = '0;
                if (shift_q == CODE) begin
                    fail_d  = '0;
                    state_d = S_OPEN;
                end else begin
                    fail_d  = (fail_q == FAIL_MAX) ? fail_q : fail_q + 2'd1;
                    state_d = (fail_d == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPEN: begin
                timer_d = timer_q + TMR_W'(1);
                if (Lock_Cmd || timer_d == UNLOCK_V) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            S_LOCKOUT: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_d == LOCKOUT_V) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase

        symbol_d     = sym_accept ? (press_a ? 2'b10 : 2'b01) : 2'b00;
        valid_d      = sym_accept;
        restart_d    = (state_d == S_IDLE) && (state_q != S_IDLE);
        unlocked_d   = (state_d == S_OPEN);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge Clock) begin
        // Edge registers track the buttons even in reset so a held button is not a press.
        prev_a_q <= Btn_A;
        prev_b_q <= Btn_B;
        if (Reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            fail_q       <= '0;
            symbol_q     <= 2'b00;
            valid_q      <= 1'b0;
            restart_q    <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            symbol_q     <= symbol_d;
            valid_q      <= valid_d;
            restart_q    <= restart_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign Symbol       = symbol_q;
    assign Symbol_Valid = valid_q;
    assign Seq_Restart  = restart_q;
    assign Unlocked     = unlocked_q;
    assign Locked_Out   = locked_out_q;
    assign Fail_Count   = fail_q;
    assign State_Code   = state_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller: symbols go through an expected queue, control
// outputs are compared at fixed cycle offsets from each stimulus step.
module tb_lock_entry_controller;

    logic       clk = 1'b0;
    logic       Reset, Btn_A, Btn_B, Lock_Cmd;
    logic [1:0] Symbol;
    logic       Symbol_Valid, Seq_Restart, Unlocked, Locked_Out;
    logic [1:0] Fail_Count;
    logic [2:0] State_Code;

    int checks      = 0;
    int failures    = 0;
    int restart_cnt = 0;
    int exp_rs      = 0;

    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    lock_entry_controller dut (
        .Clock        (clk),
        .Reset        (Reset),
        .Btn_A        (Btn_A),
        .Btn_B        (Btn_B),
        .Lock_Cmd     (Lock_Cmd),
        .Symbol       (Symbol),
        .Symbol_Valid (Symbol_Valid),
        .Seq_Restart  (Seq_Restart),
        .Unlocked     (Unlocked),
        .Locked_Out   (Locked_Out),
        .Fail_Count   (Fail_Count),
        .State_Code   (State_Code)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one button for one cycle; the symbol appears at the first negedge inside.
    task automatic press(input bit is_a, input bit accept);
        if (is_a) Btn_A = 1'b1;
        else      Btn_B = 1'b1;
        if (accept) exp_q.push_back(is_a ? 2'b10 : 2'b01);
        @(negedge clk);
        Btn_A = 1'b0;
        Btn_B = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] code);
        for (int i = 3; i >= 0; i--) press(code[i], 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_symbol"},     32'(Symbol),       32'd0);
        chk({tag, "_valid"},      32'(Symbol_Valid), 32'd0);
        chk({tag, "_restart"},    32'(Seq_Restart),  32'd0);
        chk({tag, "_unlocked"},   32'(Unlocked),     32'd0);
        chk({tag, "_locked_out"}, 32'(Locked_Out),   32'd0);
        chk({tag, "_fail"},       32'(Fail_Count),   32'd0);
        chk({tag, "_state"},      32'(State_Code),   32'd0);
    endtask

    always @(negedge clk) begin
        if (Seq_Restart) restart_cnt++;
        if (Symbol_Valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_symbol", 32'(Symbol_Valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("symbol", 32'(Symbol), 32'(mon_exp));
            end
        end
    end

    initial begin
        Reset = 1'b1; Btn_A = 1'b1; Btn_B = 1'b0; Lock_Cmd = 1'b0;
        tick(3);
        check_zero("reset");
        Reset = 1'b0;
        tick(4);
        chk("held_through_reset_state", 32'(State_Code), 32'd0);
        Btn_A = 1'b0;
        tick(2);

        // Both buttons rising together is not a press.
        Btn_A = 1'b1; Btn_B = 1'b1;
        tick(3);
        chk("dual_rise_state", 32'(State_Code), 32'd0);
        Btn_A = 1'b0; Btn_B = 1'b0;
        tick(2);

        // Correct code, presses 20 cycles apart, full unlock hold.
        press(1'b1, 1'b1); tick(18);
        press(1'b0, 1'b1); tick(18);
        press(1'b1, 1'b1); tick(18);
        Btn_B = 1'b1;
        exp_q.push_back(2'b01);
        @(negedge clk);
        chk("t1_check_state", 32'(State_Code), 32'd2);
        chk("t1_not_yet_open", 32'(Unlocked), 32'd0);
        Btn_B = 1'b0;
        @(negedge clk);
        chk("t1_unlocked", 32'(Unlocked), 32'd1);
        chk("t1_open_state", 32'(State_Code), 32'd3);
        tick(499);
        chk("t1_hold_last", 32'(Unlocked), 32'd1);
        tick(1);
        chk("t1_relock", 32'(Unlocked), 32'd0);
        chk("t1_idle", 32'(State_Code), 32'd0);
        chk("t1_restart", 32'(Seq_Restart), 32'd1);
        exp_rs++;
        tick(1);
        chk("t1_restart_one_cycle", 32'(Seq_Restart), 32'd0);
        tick(2);

        // Three wrong entries lead to lockout.
        for (int f = 1; f <= 3; f++) begin
            enter(4'b0000);
            chk("t2_fail_count", 32'(Fail_Count), 32'(f));
            if (f < 3) begin
                chk("t2_idle", 32'(State_Code), 32'd0);
                chk("t2_restart", 32'(Seq_Restart), 32'd1);
                exp_rs++;
                tick(2);
            end
        end
        chk("t2_locked_out", 32'(Locked_Out), 32'd1);
        chk("t2_lockout_state", 32'(State_Code), 32'd4);
        press(1'b1, 1'b0);
        Lock_Cmd = 1'b1;
        tick(1);
        Lock_Cmd = 1'b0;
        tick(4996);
        chk("t2_lockout_last", 32'(Locked_Out), 32'd1);
        chk("t2_lockout_last_state", 32'(State_Code), 32'd4);
        tick(1);
        chk("t2_exit_locked_out", 32'(Locked_Out), 32'd0);
        chk("t2_exit_state", 32'(State_Code), 32'd0);
        chk("t2_exit_fail", 32'(Fail_Count), 32'd0);
        chk("t2_exit_restart", 32'(Seq_Restart), 32'd1);
        exp_rs++;
        tick(2);

        // Inter-symbol timeout.
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        tick(998);
        chk("t3_still_entry", 32'(State_Code), 32'd1);
        tick(1);
        chk("t3_timeout_idle", 32'(State_Code), 32'd0);
        chk("t3_restart", 32'(Seq_Restart), 32'd1);
        chk("t3_fail_unchanged", 32'(Fail_Count), 32'd0);
        exp_rs++;
        tick(2);

        // Lock_Cmd: ignored in IDLE, aborts ENTRY and beats a same-cycle press.
        Lock_Cmd = 1'b1;
        tick(2);
        chk("lc_idle_state", 32'(State_Code), 32'd0);
        chk("lc_idle_no_restart", 32'(Seq_Restart), 32'd0);
        Lock_Cmd = 1'b0;
        tick(1);
        press(1'b1, 1'b1);
        chk("lc_entry_state", 32'(State_Code), 32'd1);
        Btn_B = 1'b1; Lock_Cmd = 1'b1;
        tick(1);
        chk("lc_abort_state", 32'(State_Code), 32'd0);
        chk("lc_abort_restart", 32'(Seq_Restart), 32'd1);
        chk("lc_abort_no_symbol", 32'(Symbol_Valid), 32'd0);
        exp_rs++;
        Btn_B = 1'b0; Lock_Cmd = 1'b0;
        tick(2);

        // Correct code, then Lock_Cmd at cycle 10 of OPEN.
        enter(4'b1010);
        chk("t4_unlocked", 32'(Unlocked), 32'd1);
        press(1'b1, 1'b0);
        tick(8);
        chk("t4_still_open", 32'(Unlocked), 32'd1);
        Lock_Cmd = 1'b1;
        tick(1);
        chk("t4_relock", 32'(Unlocked), 32'd0);
        chk("t4_idle", 32'(State_Code), 32'd0);
        chk("t4_restart", 32'(Seq_Restart), 32'd1);
        exp_rs++;
        Lock_Cmd = 1'b0;
        tick(2);

        // Reset after two symbols, then a correct entry.
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        chk("t6a_entry", 32'(State_Code), 32'd1);
        Reset = 1'b1;
        tick(1);
        check_zero("t6a");
        Reset = 1'b0;
        tick(2);
        enter(4'b1010);
        chk("t6a_unlocked", 32'(Unlocked), 32'd1);
        Lock_Cmd = 1'b1;
        tick(1);
        chk("t6a_relock_restart", 32'(Seq_Restart), 32'd1);
        exp_rs++;
        Lock_Cmd = 1'b0;
        tick(2);

        // Reset during lockout, then a correct entry.
        for (int f = 1; f <= 3; f++) begin
            enter(4'b0110);
            if (f < 3) begin
                exp_rs++;
                tick(2);
            end
        end
        chk("t6b_locked_out", 32'(Locked_Out), 32'd1);
        tick(100);
        Reset = 1'b1;
        tick(1);
        check_zero("t6b");
        Reset = 1'b0;
        tick(2);
        enter(4'b1010);
        chk("t6b_unlocked", 32'(Unlocked), 32'd1);
        chk("t6b_fail_zero", 32'(Fail_Count), 32'd0);

        tick(2);
        chk("restart_count", 32'(restart_cnt), 32'(exp_rs));
        chk("symbols_outstanding", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
